// File: rtl/dut_top.sv
// 4x4 crossbar switch: per-output round-robin arbiter feeding a FIFO of {source index, payload}.
// Each output port is one xbar_oport instance; the top only routes requests and fans grants back.

module xbar_oport #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             req_i,
   input  logic [3:0][DATA_W-1:0] data_i,
   input  logic                   rcv_rdy_i,
   output logic [3:0]             gnt_o,
   output logic                   valid_o,
   output logic [1:0]             src_o,
   output logic [DATA_W-1:0]      data_o
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [1:0]        src;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t          mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      last_q;
   logic [1:0]      win;
   logic [1:0]      cand;
   logic            found;
   logic            full, empty, push, pop;

   assign full  = (cnt_q == CW'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);

   // Fullness uses the registered count, so a same-cycle pop never admits a grant.
   always_comb begin
      gnt_o = '0;
      win   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      if (found && !full && !reset)
         gnt_o[win] = 1'b1;
   end

   assign push = |gnt_o;
   assign pop  = !empty && rcv_rdy_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= 2'd3;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= '{src: win, data: data_i[win]};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
            last_q          <= win;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   assign valid_o = !empty;
   assign src_o   = empty ? 2'd0 : mem_q[rd_ptr_q].src;
   assign data_o  = empty ? '0 : mem_q[rd_ptr_q].data;
endmodule

module dut_top #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in_0,
   input  logic              valid_in_1,
   input  logic              valid_in_2,
   input  logic              valid_in_3,
   input  logic [1:0]        addr_in_0,
   input  logic [1:0]        addr_in_1,
   input  logic [1:0]        addr_in_2,
   input  logic [1:0]        addr_in_3,
   input  logic [DATA_W-1:0] data_in_0,
   input  logic [DATA_W-1:0] data_in_1,
   input  logic [DATA_W-1:0] data_in_2,
   input  logic [DATA_W-1:0] data_in_3,
   output logic              data_rd_0,
   output logic              data_rd_1,
   output logic              data_rd_2,
   output logic              data_rd_3,
   output logic              valid_out_0,
   output logic              valid_out_1,
   output logic              valid_out_2,
   output logic              valid_out_3,
   output logic [1:0]        addr_out_0,
   output logic [1:0]        addr_out_1,
   output logic [1:0]        addr_out_2,
   output logic [1:0]        addr_out_3,
   output logic [DATA_W-1:0] data_out_0,
   output logic [DATA_W-1:0] data_out_1,
   output logic [DATA_W-1:0] data_out_2,
   output logic [DATA_W-1:0] data_out_3,
   input  logic              rcv_rdy_0,
   input  logic              rcv_rdy_1,
   input  logic              rcv_rdy_2,
   input  logic              rcv_rdy_3
);
   logic [3:0]             vin, drd, vout, rdy;
   logic [3:0][1:0]        ain, aout;
   logic [3:0][DATA_W-1:0] din, dout;
   logic [3:0][3:0]        req, gnt;   // [output][input]

   assign vin = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
   assign ain = {addr_in_3, addr_in_2, addr_in_1, addr_in_0};
   assign din = {data_in_3, data_in_2, data_in_1, data_in_0};
   assign rdy = {rcv_rdy_3, rcv_rdy_2, rcv_rdy_1, rcv_rdy_0};

   always_comb begin
      req = '0;
      drd = '0;
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 4; i++) begin
            req[j][i] = vin[i] && (ain[i] == 2'(j));
            drd[i]    = drd[i] | gnt[j][i];
         end
   end

   for (genvar j = 0; j < 4; j++) begin : g_oport
      xbar_oport #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_oport (
         .clk      (clk),
         .reset    (reset),
         .req_i    (req[j]),
         .data_i   (din),
         .rcv_rdy_i(rdy[j]),
         .gnt_o    (gnt[j]),
         .valid_o  (vout[j]),
         .src_o    (aout[j]),
         .data_o   (dout[j])
      );
   end

   assign {data_rd_3, data_rd_2, data_rd_1, data_rd_0}         = drd;
   assign {valid_out_3, valid_out_2, valid_out_1, valid_out_0} = vout;
   assign {addr_out_3, addr_out_2, addr_out_1, addr_out_0}     = aout;
   assign {data_out_3, data_out_2, data_out_1, data_out_0}     = dout;
endmodule

// File: tb/tb_dut_top.sv
// Directed bench for the 4x4 crossbar: routing, round-robin order, backpressure, parallel grants, reset flush.

module tb_dut_top;
   logic       clk = 1'b0;
   logic       reset;
   logic       vin  [4];
   logic [1:0] ain  [4];
   logic [7:0] din  [4];
   logic       rr   [4];
   logic       drd  [4];
   logic       vout [4];
   logic [1:0] aout [4];
   logic [7:0] dout [4];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dut_top #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .valid_in_0(vin[0]), .valid_in_1(vin[1]), .valid_in_2(vin[2]), .valid_in_3(vin[3]),
      .addr_in_0(ain[0]), .addr_in_1(ain[1]), .addr_in_2(ain[2]), .addr_in_3(ain[3]),
      .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
      .data_rd_0(drd[0]), .data_rd_1(drd[1]), .data_rd_2(drd[2]), .data_rd_3(drd[3]),
      .valid_out_0(vout[0]), .valid_out_1(vout[1]), .valid_out_2(vout[2]), .valid_out_3(vout[3]),
      .addr_out_0(aout[0]), .addr_out_1(aout[1]), .addr_out_2(aout[2]), .addr_out_3(aout[3]),
      .data_out_0(dout[0]), .data_out_1(dout[1]), .data_out_2(dout[2]), .data_out_3(dout[3]),
      .rcv_rdy_0(rr[0]), .rcv_rdy_1(rr[1]), .rcv_rdy_2(rr[2]), .rcv_rdy_3(rr[3])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] grants();
      return {drd[3], drd[2], drd[1], drd[0]};
   endfunction

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vin[i] = 1'b0; ain[i] = '0; din[i] = '0; rr[i] = 1'b0;
      end
      vin[0] = 1'b1;
      #1 chk("rst_drd0", drd[0], 0);
      step();
      step();
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("rst_vout%0d", j), vout[j], 0);
         chk($sformatf("rst_dout%0d", j), dout[j], 0);
      end
      chk("rst_drd0_b", drd[0], 0);

      // single word 0xA5 from input 0 to output 2
      reset = 1'b0;
      ain[0] = 2'd2; din[0] = 8'hA5; rr[2] = 1'b1;
      #1;
      chk("t1_drd0", drd[0], 1);
      chk("t1_vout2_pre", vout[2], 0);
      step();
      vin[0] = 1'b0;
      #1;
      chk("t1_drd0_off", drd[0], 0);
      chk("t1_vout2", vout[2], 1);
      chk("t1_aout2", aout[2], 0);
      chk("t1_dout2", dout[2], 8'hA5);
      step();
      #1;
      chk("t1_vout2_pop", vout[2], 0);
      chk("t1_dout2_pop", dout[2], 0);
      rr[2] = 1'b0;

      // all four inputs contend for output 1: round-robin 0,1,2,3,0,1
      rr[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vin[i] = 1'b1; ain[i] = 2'd1; din[i] = 8'h10 + 8'(i);
      end
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("t2_gnt%0d", k), grants(), 4'b0001 << (k % 4));
         if (k > 0) begin
            chk($sformatf("t2_aout%0d", k), aout[1], (k - 1) % 4);
            chk($sformatf("t2_dout%0d", k), dout[1], 8'h10 + (k - 1) % 4);
         end
         step();
      end
      for (int i = 0; i < 4; i++) vin[i] = 1'b0;
      #1;
      chk("t2_tail_aout", aout[1], 1);
      chk("t2_tail_vout", vout[1], 1);
      step();
      #1;
      chk("t2_empty", vout[1], 0);
      rr[1] = 1'b0;

      // backpressure on output 3: exactly four words accepted
      vin[2] = 1'b1; ain[2] = 2'd3; din[2] = 8'h30;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("t3_drd2_c%0d", c), drd[2], (c < 4) ? 1 : 0);
         step();
         if (c < 4) din[2] = 8'h31 + 8'(c);
      end
      rr[3] = 1'b1;
      #1;
      chk("t3_full_nogrant", drd[2], 0);
      chk("t3_head0", dout[3], 8'h30);
      step();
      #1;
      chk("t3_regrant", drd[2], 1);
      chk("t3_head1", dout[3], 8'h31);
      step();
      vin[2] = 1'b0;
      for (int n = 2; n <= 4; n++) begin
         #1;
         chk($sformatf("t3_head%0d", n), dout[3], 8'h30 + 8'(n));
         chk($sformatf("t3_src%0d", n), aout[3], 2);
         step();
      end
      #1;
      chk("t3_drained", vout[3], 0);

      // parallel: inputs 0..3 to outputs 3..0
      for (int i = 0; i < 4; i++) begin
         vin[i] = 1'b1; ain[i] = 2'(3 - i); din[i] = 8'h40 + 8'(i); rr[i] = 1'b1;
      end
      #1;
      chk("t4_all_gnt", grants(), 4'hF);
      step();
      for (int i = 0; i < 4; i++) vin[i] = 1'b0;
      #1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("t4_vout%0d", j), vout[j], 1);
         chk($sformatf("t4_aout%0d", j), aout[j], 3 - j);
         chk($sformatf("t4_dout%0d", j), dout[j], 8'h40 + 3 - j);
      end
      step();
      #1;
      chk("t4_empty", {vout[3], vout[2], vout[1], vout[0]}, 0);

      // reset with two words queued at output 0
      for (int i = 0; i < 4; i++) rr[i] = 1'b0;
      vin[0] = 1'b1; ain[0] = 2'd0; din[0] = 8'h50;
      step();
      din[0] = 8'h51;
      step();
      vin[0] = 1'b0;
      #1;
      chk("t5_queued", dout[0], 8'h50);
      reset = 1'b1;
      vin[1] = 1'b1; ain[1] = 2'd0; din[1] = 8'h77;
      #1;
      chk("t5_rst_drd1", drd[1], 0);
      step();
      chk("t5_vout0", vout[0], 0);
      chk("t5_aout0", aout[0], 0);
      chk("t5_dout0", dout[0], 0);
      reset = 1'b0; vin[1] = 1'b0; rr[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("t5_nostale%0d", c), vout[0], 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/dut_top.md
DUT_TOP -- requirements
Module: dut_top

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload width per packet word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning entries per output-port queue (power of two).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have, for each input port i in 0..3, port valid_in_i, input, 1, meaning the source presents a word.
REQ-006 The block SHALL have, for each input port i, port addr_in_i, input, 2, meaning the destination output index.
REQ-007 The block SHALL have, for each input port i, port data_in_i, input, DATA_W, meaning the payload.
REQ-008 The block SHALL have, for each input port i, port data_rd_i, output, 1, meaning the word is accepted this cycle.
REQ-009 The block SHALL have, for each output port j in 0..3, port valid_out_j, output, 1, meaning a word is presented.
REQ-010 The block SHALL have, for each output port j, port addr_out_j, output, 2, meaning the source input index of the presented word.
REQ-011 The block SHALL have, for each output port j, port data_out_j, output, DATA_W, meaning the presented payload.
REQ-012 The block SHALL have, for each output port j, port rcv_rdy_j, input, 1, meaning the sink takes the word this cycle.

Function
REQ-013 The block SHALL be a 4x4 crossbar: each word entering input i with addr_in_i=j SHALL leave output j with addr_out_j=i and unchanged data.
REQ-014 Each output j SHALL own a FIFO of FIFO_DEPTH entries, each entry holding {source index, data}.
REQ-015 Input i SHALL request output j when valid_in_i=1 and addr_in_i=j.
REQ-016 Output j SHALL grant at most one requester per cycle, and only when its FIFO is not full; a pop in the same cycle SHALL NOT free space for that cycle's grant.
REQ-017 Arbitration SHALL be round-robin per output: search order starts at (last_granted_j+1) mod 4; last_granted_j SHALL update only on a grant.
REQ-018 data_rd_i SHALL be combinational, high in exactly the cycle input i is granted; the word SHALL be written into the FIFO at that rising edge.
REQ-019 A source SHALL hold valid/addr/data stable until data_rd_i=1; the block SHALL accept each held word exactly once.
REQ-020 valid_out_j SHALL equal FIFO-not-empty; addr_out_j/data_out_j SHALL show the head entry, and SHALL be 0 when empty.
REQ-021 A pop SHALL occur when valid_out_j=1 and rcv_rdy_j=1 at a rising edge; outputs SHALL hold while rcv_rdy_j=0.
REQ-022 Minimum latency SHALL be one cycle: a word accepted at edge k SHALL appear on valid_out_j after edge k and can pop at edge k+1.
REQ-023 Simultaneous push and pop on a non-empty FIFO SHALL keep the count unchanged; order SHALL be strict FIFO per output.
REQ-024 Outputs SHALL operate independently, so different inputs targeting different outputs are all granted in the same cycle.

Reset
REQ-025 While reset=1 at a rising edge, all FIFOs SHALL empty and all last_granted_j SHALL be set to 3, giving input 0 first priority.
REQ-026 While reset=1, data_rd_i SHALL be 0 and valid_out_j, addr_out_j and data_out_j SHALL be 0 after the edge.
REQ-027 Words in flight at reset SHALL be discarded; reset mid-operation SHALL NOT emit partial or duplicate words.

Verification
REQ-028 Stimulus: input 0 sends 0xA5 to output 2 with rcv_rdy_2=1. Response: data_rd_0=1 for one cycle; next cycle valid_out_2=1, addr_out_2=0, data_out_2=0xA5.
REQ-029 Stimulus: inputs 0..3 all target output 1 continuously after reset, with rcv_rdy_1=1. Response: grants go to 0,1,2,3,0,... with one grant per cycle.
REQ-030 Stimulus: rcv_rdy_3=0 while input 2 streams to output 3. Response: exactly 4 words are accepted, then data_rd_2 stays 0; raising rcv_rdy_3 drains them in order and accepts resume.
REQ-031 Stimulus: inputs 0..3 target outputs 3,2,1,0 at once. Response: all four data_rd are high in the same cycle and each output carries its correct source index.
REQ-032 Stimulus: reset is asserted with 2 words queued at output 0. Response: valid_out_0=0 after the edge and no stale word appears later.
REQ-033 Stimulus: a full FIFO with rcv_rdy=1 and a pending request. Response: the pop occurs this cycle and the grant occurs the next cycle.
